// File: rtl/enoc_node_interface_pkg.sv
// Shared ENoC definitions: packet layout and a constant-evaluable log2 helper.
// Field widths are fixed here so every node and router agrees on packet_t.
package ENoC_Functions;

  // Ceiling log2, usable in localparam expressions.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam int ENOC_NODES = 16;
  localparam int ID_W       = log2(ENOC_NODES);
  localparam int DATA_W     = 32;
  localparam int TS_W       = 16;

  typedef struct packed {
    logic [ID_W-1:0]   source;
    logic [ID_W-1:0]   dest;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   timestamp;
  } packet_t;

endpackage

// File: rtl/enoc_node_interface_fifo.sv
// Valid/enable FIFO used for both directions of the node link.
// Enable and valid are decoded purely from the registered pointers, so neither depends on the far side.
module enoc_fifo
  import ENoC_Functions::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = packet_t
) (
  input  logic clk,
  input  logic reset_n,
  input  T     i_data,
  input  logic i_data_val,
  output logic o_en,
  output T     o_data,
  output logic o_data_val,
  input  logic i_en
);

  localparam int AW = log2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  T              mem [DEPTH];
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // The extra pointer MSB distinguishes full from empty when the index bits match.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign o_en       = !full;
  assign o_data_val = !empty;
  assign o_data     = mem[rd_ptr[AW-1:0]];
  assign push       = i_data_val & o_en;
  assign pop        = o_data_val & i_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are only visible once the write pointer passes them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/enoc_node_interface.sv
// Node-side endpoint of the ENoC local port: TX and RX queues plus per-node traffic statistics.
// Misrouted arrivals are still delivered; they only set a sticky flag.
module enoc_node_interface
  import ENoC_Functions::*;
#(
  parameter int NODE_ID  = 0,
  parameter int NODES    = 16,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  packet_t          i_pkt,
  input  logic             i_pkt_val,
  output logic             o_pkt_en,
  output packet_t          o_data,
  output logic             o_data_val,
  input  logic             i_en,
  input  packet_t          i_data,
  input  logic             i_data_val,
  output logic             o_en,
  output packet_t          o_rx_pkt,
  output logic             o_rx_val,
  input  logic             i_rx_en,
  output logic [CNT_W-1:0] o_tx_count,
  output logic [CNT_W-1:0] o_rx_count,
  output logic             o_misroute
);

  localparam logic [ID_W-1:0] NODE_ADDR = ID_W'(NODE_ID % NODES);

  logic tx_handshake;
  logic rx_handshake;

  enoc_fifo #(.DEPTH(TX_DEPTH), .T(packet_t)) tx_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_data     (i_pkt),
    .i_data_val (i_pkt_val),
    .o_en       (o_pkt_en),
    .o_data     (o_data),
    .o_data_val (o_data_val),
    .i_en       (i_en)
  );

  enoc_fifo #(.DEPTH(RX_DEPTH), .T(packet_t)) rx_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_data     (i_data),
    .i_data_val (i_data_val),
    .o_en       (o_en),
    .o_data     (o_rx_pkt),
    .o_data_val (o_rx_val),
    .i_en       (i_rx_en)
  );

  assign tx_handshake = o_data_val & i_en;
  assign rx_handshake = i_data_val & o_en;

  // Counters wrap freely; the misroute flag is sticky until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_tx_count <= '0;
      o_rx_count <= '0;
      o_misroute <= 1'b0;
    end else begin
      if (tx_handshake) o_tx_count <= o_tx_count + CNT_W'(1);
      if (rx_handshake) o_rx_count <= o_rx_count + CNT_W'(1);
      if (rx_handshake && (i_data.dest != NODE_ADDR)) o_misroute <= 1'b1;
    end
  end

endmodule

// File: tb/tb_enoc_node_interface.sv
// Self-checking bench for enoc_node_interface: per-cycle flag table plus packet scoreboards on both links.
module tb_enoc_node_interface;
  import ENoC_Functions::*;

  localparam int NODE_ID = 3;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  packet_t          i_pkt;
  logic             i_pkt_val;
  logic             o_pkt_en;
  packet_t          o_data;
  logic             o_data_val;
  logic             i_en;
  packet_t          i_data;
  logic             i_data_val;
  logic             o_en;
  packet_t          o_rx_pkt;
  logic             o_rx_val;
  logic             i_rx_en;
  logic [CNT_W-1:0] o_tx_count;
  logic [CNT_W-1:0] o_rx_count;
  logic             o_misroute;

  enoc_node_interface #(
    .NODE_ID(NODE_ID), .NODES(16), .TX_DEPTH(4), .RX_DEPTH(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_pkt(i_pkt), .i_pkt_val(i_pkt_val), .o_pkt_en(o_pkt_en),
    .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en),
    .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en),
    .o_rx_pkt(o_rx_pkt), .o_rx_val(o_rx_val), .i_rx_en(i_rx_en),
    .o_tx_count(o_tx_count), .o_rx_count(o_rx_count), .o_misroute(o_misroute)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  packet_t txExp[$];
  packet_t rxExp[$];
  int txSeq = 0;
  int rxSeq = 0;
  logic txTake = 1'b0;
  logic rxTake = 1'b0;
  logic [ID_W-1:0] rxDest = ID_W'(NODE_ID);

  typedef struct {
    logic pktVal;
    logic en;
    logic dataVal;
    logic rxEn;
    logic expPktEn;
    logic expDataVal;
    logic expEn;
    logic expRxVal;
  } vec_t;

  vec_t vecs[$];

  function automatic packet_t makePkt(input int seq, input logic [ID_W-1:0] src,
                                      input logic [ID_W-1:0] dst);
    packet_t p;
    p.source    = src;
    p.dest      = dst;
    p.data      = 32'hA500_0000 ^ DATA_W'(seq);
    p.timestamp = TS_W'(seq * 7 + 1);
    return p;
  endfunction

  // Sources hold their packet until it is accepted, like a real producer.
  assign i_pkt  = makePkt(txSeq, ID_W'(NODE_ID), ID_W'((txSeq % 4) + 1));
  assign i_data = makePkt(1000 + rxSeq, ID_W'(5), rxDest);

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic en, input logic dv, input logic rxEn);
    i_pkt_val  = pv;
    i_en       = en;
    i_data_val = dv;
    i_rx_en    = rxEn;
    @(posedge clk);
    #1;
  endtask

  function automatic void addVec(input logic pv, en, dv, rxEn, ePe, eDv, eEn, eRv);
    vec_t v;
    v.pktVal = pv; v.en = en; v.dataVal = dv; v.rxEn = rxEn;
    v.expPktEn = ePe; v.expDataVal = eDv; v.expEn = eEn; v.expRxVal = eRv;
    vecs.push_back(v);
  endfunction

  // Scoreboards: decide at the falling edge which handshakes the next rising edge will perform.
  always @(negedge clk) begin
    txTake = 1'b0;
    rxTake = 1'b0;
    if (reset_n) begin
      if (o_data_val && i_en) begin
        if (txExp.size() == 0) checkOutput("tx_unexpected_pkt", 64'(o_data), 64'(0));
        else                   checkOutput("tx_pkt_order", 64'(o_data), 64'(txExp.pop_front()));
      end
      if (o_rx_val && i_rx_en) begin
        if (rxExp.size() == 0) checkOutput("rx_unexpected_pkt", 64'(o_rx_pkt), 64'(0));
        else                   checkOutput("rx_pkt_order", 64'(o_rx_pkt), 64'(rxExp.pop_front()));
      end
      if (i_pkt_val && o_pkt_en) begin
        txExp.push_back(i_pkt);
        txTake = 1'b1;
      end
      if (i_data_val && o_en) begin
        rxExp.push_back(i_data);
        rxTake = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (txTake) txSeq <= txSeq + 1;
    if (rxTake) rxSeq <= rxSeq + 1;
  end

  task automatic checkFlags(input string tag, input logic ePe, eDv, eEn, eRv);
    checkOutput({tag, "_pkt_en"},   64'(o_pkt_en),   64'(ePe));
    checkOutput({tag, "_data_val"}, 64'(o_data_val), 64'(eDv));
    checkOutput({tag, "_en"},       64'(o_en),       64'(eEn));
    checkOutput({tag, "_rx_val"},   64'(o_rx_val),   64'(eRv));
  endtask

  initial begin
    // TX throughput: back-to-back pushes with the network always accepting.
    addVec(1,1,0,0, 1,1,1,0); addVec(1,1,0,0, 1,1,1,0);
    addVec(1,1,0,0, 1,1,1,0); addVec(1,1,0,0, 1,1,1,0);
    addVec(0,1,0,0, 1,0,1,0);
    // TX backpressure: fill to 4, offered packets refused, then drain.
    addVec(1,0,0,0, 1,1,1,0); addVec(1,0,0,0, 1,1,1,0);
    addVec(1,0,0,0, 1,1,1,0); addVec(1,0,0,0, 0,1,1,0);
    addVec(1,0,0,0, 0,1,1,0); addVec(1,0,0,0, 0,1,1,0);
    addVec(1,1,0,0, 1,1,1,0); addVec(0,1,0,0, 1,1,1,0);
    addVec(0,1,0,0, 1,1,1,0); addVec(0,1,0,0, 1,0,1,0);
    // RX full: sink stalled, fifth packet held, one-cycle sink pulse, then drain.
    addVec(0,0,1,0, 1,0,1,1); addVec(0,0,1,0, 1,0,1,1);
    addVec(0,0,1,0, 1,0,1,1); addVec(0,0,1,0, 1,0,0,1);
    addVec(0,0,1,0, 1,0,0,1); addVec(0,0,1,1, 1,0,1,1);
    addVec(0,0,1,0, 1,0,0,1); addVec(0,0,0,1, 1,0,1,1);
    addVec(0,0,0,1, 1,0,1,1); addVec(0,0,0,1, 1,0,1,1);
    addVec(0,0,0,1, 1,0,1,0);

    reset_n = 1'b0;
    i_pkt_val = 1'b0; i_en = 1'b0; i_data_val = 1'b0; i_rx_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkFlags("in_reset", 1, 0, 1, 0);
    reset_n = 1'b1;
    #1;
    checkFlags("idle", 1, 0, 1, 0);
    checkOutput("idle_tx_count", 64'(o_tx_count), 64'(0));
    checkOutput("idle_rx_count", 64'(o_rx_count), 64'(0));
    checkOutput("idle_misroute", 64'(o_misroute), 64'(0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].pktVal, vecs[i].en, vecs[i].dataVal, vecs[i].rxEn);
      checkFlags($sformatf("vec%0d", i), vecs[i].expPktEn, vecs[i].expDataVal,
                 vecs[i].expEn, vecs[i].expRxVal);
    end
    checkOutput("tx_count_8", 64'(o_tx_count), 64'(8));
    checkOutput("rx_count_5", 64'(o_rx_count), 64'(5));
    checkOutput("misroute_clean", 64'(o_misroute), 64'(0));

    // Misroute: a foreign packet sets the flag but is still delivered.
    rxDest = ID_W'(NODE_ID + 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("misroute_set", 64'(o_misroute), 64'(1));
    checkOutput("misroute_rx_val", 64'(o_rx_val), 64'(1));
    checkOutput("misroute_dest", 64'(o_rx_pkt.dest), 64'(NODE_ID + 1));
    rxDest = ID_W'(NODE_ID);
    repeat (10) applyStimulus(0, 0, 1, 1);
    repeat (2) applyStimulus(0, 0, 0, 1);
    checkOutput("misroute_sticky", 64'(o_misroute), 64'(1));
    checkOutput("rx_count_16", 64'(o_rx_count), 64'(16));
    checkOutput("rx_drained", 64'(o_rx_val), 64'(0));

    // Asynchronous reset between edges with two entries in each queue.
    repeat (2) applyStimulus(1, 0, 1, 0);
    checkFlags("pre_reset", 1, 1, 1, 1);
    #3;
    reset_n = 1'b0;
    i_pkt_val = 1'b0; i_data_val = 1'b0;
    txExp.delete();
    rxExp.delete();
    #1;
    checkFlags("async_reset", 1, 0, 1, 0);
    checkOutput("async_tx_count", 64'(o_tx_count), 64'(0));
    checkOutput("async_rx_count", 64'(o_rx_count), 64'(0));
    checkOutput("async_misroute", 64'(o_misroute), 64'(0));
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 1);
      checkFlags($sformatf("post_reset%0d", i), 1, 0, 1, 0);
    end

    checkOutput("tx_scoreboard_empty", 64'(txExp.size()), 64'(0));
    checkOutput("rx_scoreboard_empty", 64'(rxExp.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
